// File: rtl/float_sub.sv
// float_sub: multi-cycle IEEE-754 single-precision A-B (OP_SUB=1) or A+B (OP_SUB=0).
//   Denormals are flushed to zero and rounding is to nearest even.
// Latency: fixed 5 cycles from the accepting edge to the ready pulse; one operation in flight.
// Backpressure: none; start is ignored while busy, and float_out holds until the next result.
// Ports: clk; rst (async, active-low); start (request, sampled in IDLE); float_in_1/float_in_2 (operands);
//        float_out (result); ready (one-cycle result strobe); busy (operation in flight).
module float_sub #(
    parameter bit OP_SUB = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] float_in_1,
    input  logic [31:0] float_in_2,
    output logic [31:0] float_out,
    output logic        ready,
    output logic        busy
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_ALIGN  = 3'd2;
    localparam logic [2:0] S_ADD    = 3'd3;
    localparam logic [2:0] S_NORM   = 3'd4;
    localparam logic [2:0] S_ROUND  = 3'd5;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    logic [2:0]         state_q, state_d;
    logic [31:0]        opa_q, opa_d, opb_q, opb_d;
    logic               spec_q, spec_d;
    logic [31:0]        spec_val_q, spec_val_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [7:0]         ea_q, ea_d, eb_q, eb_d;
    logic [23:0]        ma_q, ma_d, mb_q, mb_d;
    logic               sign_q, sign_d, sub_q, sub_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [26:0]        fa_q, fa_d, fb_q, fb_d;
    logic [27:0]        sum_q, sum_d;
    logic               zero_q, zero_d;
    logic [25:0]        frac_q, frac_d;   // normalised fraction (hidden bit dropped) + guard, round, sticky
    logic [31:0]        out_q, out_d;
    logic               ready_q, ready_d, busy_q, busy_d;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

    // Unpack helpers
    logic [7:0] ua_e, ub_e;
    logic       ua_nan, ub_nan, ua_inf, ub_inf, ub_s;
    assign ua_e   = opa_q[30:23];
    assign ub_e   = opb_q[30:23];
    assign ua_nan = (ua_e == 8'hFF) && (opa_q[22:0] != 23'd0);
    assign ub_nan = (ub_e == 8'hFF) && (opb_q[22:0] != 23'd0);
    assign ua_inf = (ua_e == 8'hFF) && (opa_q[22:0] == 23'd0);
    assign ub_inf = (ub_e == 8'hFF) && (opb_q[22:0] == 23'd0);
    assign ub_s   = opb_q[31] ^ OP_SUB;

    // Align helpers: larger magnitude goes to A, smaller is shifted right with sticky collection
    logic        swap, big_s;
    logic [7:0]  big_e, sml_e, diff;
    logic [23:0] big_m, sml_m;
    logic [26:0] sml_f, shifted, lost, aligned;
    assign swap    = {eb_q, mb_q} > {ea_q, ma_q};
    assign big_s   = swap ? sb_q : sa_q;
    assign big_e   = swap ? eb_q : ea_q;
    assign big_m   = swap ? mb_q : ma_q;
    assign sml_e   = swap ? ea_q : eb_q;
    assign sml_m   = swap ? ma_q : mb_q;
    assign diff    = big_e - sml_e;
    assign sml_f   = {sml_m, 3'b000};
    assign shifted = sml_f >> diff;
    assign lost    = sml_f & ((27'd1 << diff) - 27'd1);
    assign aligned = (diff >= 8'd27) ? {26'd0, |sml_m} : (shifted | {26'd0, |lost});

    // Normalise helpers
    logic [4:0]        lzc;
    logic [26:0]       nval;
    logic signed [9:0] nexp;
    assign lzc = lzc27(sum_q[26:0]);
    always_comb begin
        if (sum_q[27]) begin
            nval = {sum_q[27:2], sum_q[1] | sum_q[0]};
            nexp = exp_q + 10'sd1;
        end else begin
            nval = sum_q[26:0] << lzc;
            nexp = exp_q - $signed({5'd0, lzc});
        end
    end

    // Round helpers
    logic              inc, carry;
    logic [22:0]       frac_r;
    logic signed [9:0] exp_r;
    logic [31:0]       result;
    assign inc = frac_q[2] & (frac_q[1] | frac_q[0] | frac_q[3]);
    assign {carry, frac_r} = {1'b0, frac_q[25:3]} + {23'd0, inc};
    assign exp_r = carry ? exp_q + 10'sd1 : exp_q;
    always_comb begin
        if (spec_q)                 result = spec_val_q;
        else if (zero_q)            result = 32'h0000_0000;
        else if (exp_r >= 10'sd255) result = {sign_q, 8'hFF, 23'd0};
        else if (exp_r <= 10'sd0)   result = {sign_q, 31'd0};
        else                        result = {sign_q, exp_r[7:0], frac_r};
    end

    always_comb begin
        state_d = state_q;  opa_d = opa_q;  opb_d = opb_q;
        spec_d = spec_q;    spec_val_d = spec_val_q;
        sa_d = sa_q;  sb_d = sb_q;  ea_d = ea_q;  eb_d = eb_q;  ma_d = ma_q;  mb_d = mb_q;
        sign_d = sign_q;  sub_d = sub_q;  exp_d = exp_q;  fa_d = fa_q;  fb_d = fb_q;
        sum_d = sum_q;  zero_d = zero_q;  frac_d = frac_q;
        out_d = out_q;  ready_d = 1'b0;  busy_d = busy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d   = float_in_1;
                    opb_d   = float_in_2;
                    busy_d  = 1'b1;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sa_d = opa_q[31];
                sb_d = ub_s;
                ea_d = ua_e;
                eb_d = ub_e;
                ma_d = (ua_e == 8'd0) ? 24'd0 : {1'b1, opa_q[22:0]};
                mb_d = (ub_e == 8'd0) ? 24'd0 : {1'b1, opb_q[22:0]};
                spec_d = ua_nan | ub_nan | ua_inf | ub_inf;
                if (ua_nan || ub_nan || (ua_inf && ub_inf && (opa_q[31] != ub_s))) spec_val_d = QNAN;
                else if (ua_inf)                                               spec_val_d = {opa_q[31], 8'hFF, 23'd0};
                else                                                           spec_val_d = {ub_s, 8'hFF, 23'd0};
                state_d = S_ALIGN;
            end
            S_ALIGN: begin
                sign_d  = big_s;
                sub_d   = sa_q ^ sb_q;
                exp_d   = $signed({2'b00, big_e});
                fa_d    = {big_m, 3'b000};
                fb_d    = aligned;
                state_d = S_ADD;
            end
            S_ADD: begin
                // After the swap A >= B, so the difference never goes negative.
                sum_d   = sub_q ? ({1'b0, fa_q} - {1'b0, fb_q}) : ({1'b0, fa_q} + {1'b0, fb_q});
                state_d = S_NORM;
            end
            S_NORM: begin
                // A normalised non-zero value always has bit 26 set, so its absence means zero.
                frac_d  = nval[25:0];
                zero_d  = ~nval[26];
                exp_d   = nexp;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                out_d   = result;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;  opa_q <= '0;  opb_q <= '0;
            spec_q <= 1'b0;     spec_val_q <= '0;
            sa_q <= 1'b0;  sb_q <= 1'b0;  ea_q <= '0;  eb_q <= '0;  ma_q <= '0;  mb_q <= '0;
            sign_q <= 1'b0;  sub_q <= 1'b0;  exp_q <= '0;  fa_q <= '0;  fb_q <= '0;
            sum_q <= '0;  zero_q <= 1'b0;  frac_q <= '0;
            out_q <= '0;  ready_q <= 1'b0;  busy_q <= 1'b0;
        end else begin
            state_q <= state_d;  opa_q <= opa_d;  opb_q <= opb_d;
            spec_q <= spec_d;    spec_val_q <= spec_val_d;
            sa_q <= sa_d;  sb_q <= sb_d;  ea_q <= ea_d;  eb_q <= eb_d;  ma_q <= ma_d;  mb_q <= mb_d;
            sign_q <= sign_d;  sub_q <= sub_d;  exp_q <= exp_d;  fa_q <= fa_d;  fb_q <= fb_d;
            sum_q <= sum_d;  zero_q <= zero_d;  frac_q <= frac_d;
            out_q <= out_d;  ready_q <= ready_d;  busy_q <= busy_d;
        end
    end

    assign float_out = out_q;
    assign ready     = ready_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_float_sub.sv
module tb_float_sub;
    localparam int N_RAND = 8000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] in1, in2;
    logic [31:0] out_s, out_a;
    logic        ready_s, ready_a, busy_s, busy_a;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    float_sub #(.OP_SUB(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .float_in_1(in1), .float_in_2(in2),
        .float_out(out_s), .ready(ready_s), .busy(busy_s)
    );
    float_sub #(.OP_SUB(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .float_in_1(in1), .float_in_2(in2),
        .float_out(out_a), .ready(ready_a), .busy(busy_a)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: operands become exact reals (FTZ on input), the sum is formed in double precision,
    // then rounded to a 24-bit significand (nearest-even) with FTZ / overflow applied on output.
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] de;
        if (f[30:23] == 8'd0) return 0.0;
        de = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], de, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b, input bit sub);
        real         r;
        logic [63:0] d;
        int          e;
        logic [52:0] m;
        logic [24:0] kr;
        logic        inc;
        r = sub ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b));
        if (r == 0.0) return 32'h0000_0000;
        d   = $realtobits(r);
        e   = int'(d[62:52]) - 896;
        m   = {1'b1, d[51:0]};
        inc = m[28] & ((|m[27:0]) | m[29]);
        kr  = {1'b0, m[52:29]} + {24'd0, inc};
        if (kr[24]) begin
            e++;
            kr = 25'd0;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0)   return {d[63], 31'd0};
        return {d[63], 8'(e), kr[22:0]};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] es, input logic [31:0] ea, input bit full);
        int lat;
        bit got;
        in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        if (full) chk({tag, ".busy0"}, {30'd0, busy_a, busy_s}, 32'd3);
        lat = 0; got = 1'b0;
        while (!got && lat < 10) begin
            @(posedge clk); #1; lat++;
            if (ready_s) got = 1'b1;
            else if (full) chk({tag, ".busy"}, {30'd0, busy_a, busy_s}, 32'd3);
        end
        chk({tag, ".lat"}, 32'(lat), 32'd5);
        chk({tag, ".sub"}, out_s, es);
        chk({tag, ".rdy_add"}, {31'd0, ready_a}, 32'd1);
        chk({tag, ".add"}, out_a, ea);
        if (full) begin
            @(posedge clk); #1;
            chk({tag, ".pulse"}, {30'd0, ready_a, ready_s}, 32'd0);
            chk({tag, ".hold"}, out_s, es);
        end
    endtask

    logic [31:0] dir_a [13] = '{32'h3FC00000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000,
                                32'h7F7FFFFF, 32'h7FC00000, 32'h80000000, 32'h00800000, 32'hFF800000,
                                32'h3F800000, 32'h7F800000, 32'h00000001};
    logic [31:0] dir_b [13] = '{32'h3F000000, 32'h3F800000, 32'hB3800000, 32'h33800000, 32'h7F800000,
                                32'hFF7FFFFF, 32'h3F800000, 32'h00000000, 32'h00800001, 32'h3F800000,
                                32'hFF800000, 32'hFF800000, 32'h3F800000};
    logic [31:0] dir_s [13] = '{32'h3F800000, 32'h00000000, 32'h3F800000, 32'h3F7FFFFF, 32'h7FC00000,
                                32'h7F800000, 32'h7FC00000, 32'h00000000, 32'h80000000, 32'hFF800000,
                                32'h7F800000, 32'h7F800000, 32'hBF800000};
    logic [31:0] dir_p [13] = '{32'h40000000, 32'h40000000, 32'h3F7FFFFF, 32'h3F800000, 32'h7F800000,
                                32'h00000000, 32'h7FC00000, 32'h00000000, 32'h01000000, 32'hFF800000,
                                32'hFF800000, 32'h7FC00000, 32'h3F800000};

    initial begin
        int nrdy;
        int lat;
        rst = 1'b0; start = 1'b0; in1 = '0; in2 = '0;
        #3;
        chk("reset.out", out_s, 32'h0);
        chk("reset.flags", {28'd0, ready_a, busy_a, ready_s, busy_s}, 32'd0);
        @(posedge clk); #1;
        chk("reset.out_add", out_a, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed values, both OP_SUB builds in parallel.
        for (int i = 0; i < 13; i++) run_op($sformatf("dir%0d", i), dir_a[i], dir_b[i], dir_s[i], dir_p[i], 1'b1);

        // start held high: results every 6 cycles.
        in1 = 32'h3F800000; in2 = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        nrdy = 0;
        for (lat = 1; lat <= 17; lat++) begin
            @(posedge clk); #1;
            if (ready_s) begin
                nrdy++;
                chk("held.lat_mod6", 32'(lat % 6), 32'd5);
                chk("held.sub", out_s, 32'hBF800000);
                chk("held.add", out_a, 32'h40400000);
            end
            if (lat == 17) start = 1'b0;
        end
        chk("held.count", 32'(nrdy), 32'd3);
        nrdy = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ready_s || ready_a) nrdy++;
        end
        chk("held.drain", 32'(nrdy), 32'd0);

        // Toggling start and operands while busy: no extra ready, no recapture.
        in1 = 32'h3FC00000; in2 = 32'h3F000000; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (lat = 1; lat <= 5; lat++) begin
            @(posedge clk); #1;
            if (lat <= 3) begin
                start = lat[0];
                in1 = $urandom; in2 = $urandom;
            end else begin
                start = 1'b0;
            end
            if (lat == 5) begin
                chk("toggle.ready", {31'd0, ready_s}, 32'd1);
                chk("toggle.sub", out_s, 32'h3F800000);
                chk("toggle.add", out_a, 32'h40000000);
            end
        end
        nrdy = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ready_s || ready_a) nrdy++;
        end
        chk("toggle.extra", 32'(nrdy), 32'd0);

        // Asynchronous reset during ADD discards the operation.
        in1 = 32'h40400000; in2 = 32'h3F800000; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        chk("arst.out_sub", out_s, 32'h0);
        chk("arst.out_add", out_a, 32'h0);
        chk("arst.flags", {28'd0, ready_a, busy_a, ready_s, busy_s}, 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        nrdy = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ready_s || ready_a) nrdy++;
        end
        chk("arst.no_ready", 32'(nrdy), 32'd0);
        run_op("after_rst", 32'h40400000, 32'h3F800000, 32'h40000000, 32'h40800000, 1'b1);

        // Random normal operands against the reference model.
        for (int i = 0; i < N_RAND; i++) begin
            logic [31:0] a, b;
            int e1, e2;
            e1 = int'($urandom_range(254, 1));
            case ($urandom_range(3, 0))
                0:       e2 = int'($urandom_range(254, 1));
                1, 2:    e2 = e1 + int'($urandom_range(4, 0)) - 2;
                default: e2 = e1;
            endcase
            if (e2 < 1)   e2 = 1;
            if (e2 > 254) e2 = 254;
            a = {1'($urandom), 8'(e1), 23'($urandom)};
            b = {1'($urandom), 8'(e2), 23'($urandom)};
            if ($urandom_range(7, 0) == 0) b[22:0] = a[22:0];
            run_op("rand", a, b, ref_op(a, b, 1'b1), ref_op(a, b, 1'b0), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
